// File: rtl/hazard5_muldiv_ctrl.sv
// Execute-stage controller for hazard5_muldiv_seq: issues M-extension ops, stalls
// the pipe until the result returns, and short-circuits fused pairs via a one-entry cache.
module hazard5_muldiv_ctrl #(
  parameter int XLEN     = 32,
  parameter int CACHE_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            x_valid,
  input  logic [2:0]      x_funct3,
  input  logic [XLEN-1:0] x_rs1,
  input  logic [XLEN-1:0] x_rs2,
  input  logic            x_kill,
  output logic            x_stall,
  output logic [XLEN-1:0] x_result,
  output logic            x_result_vld,
  output logic [2:0]      op,
  output logic            op_vld,
  input  logic            op_rdy,
  output logic            op_force,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] result_h,
  input  logic [XLEN-1:0] result_l,
  input  logic            result_vld
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0] F3_MUL  = 3'd0;
  localparam logic [2:0] F3_DIV  = 3'd4;
  localparam logic [2:0] F3_DIVU = 3'd5;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [2:0]      r_funct3;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;

  logic            r_c_vld;
  logic [2:0]      r_c_op;
  logic [XLEN-1:0] r_c_a;
  logic [XLEN-1:0] r_c_b;
  logic [XLEN-1:0] r_c_hi;
  logic [XLEN-1:0] r_c_lo;

  logic            w_compat;
  logic            w_hit;
  logic            w_capture;
  logic            w_take_hit;
  logic            w_take_res;

  // REM/REMU ride on the DIV/DIVU run (remainder comes back on result_h).
  function automatic logic [2:0] seq_op(input logic [2:0] f3);
    return f3[2] ? (f3 & 3'b101) : f3;
  endfunction

  function automatic logic [XLEN-1:0] pick_half(input logic [2:0]      f3,
                                                input logic [XLEN-1:0] hi,
                                                input logic [XLEN-1:0] lo);
    return (f3 == F3_MUL || f3 == F3_DIV || f3 == F3_DIVU) ? lo : hi;
  endfunction

  // MUL only needs the low product half, which every mul-class run produces identically.
  always_comb begin
    w_compat = 1'b0;
    if (x_funct3 == F3_MUL) w_compat = !r_c_op[2];
    else                    w_compat = (r_c_op == seq_op(x_funct3));
    w_hit = (CACHE_EN != 0) && r_c_vld && (r_c_a == x_rs1) && (r_c_b == x_rs2) && w_compat;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    op_vld       = 1'b0;
    x_result_vld = 1'b0;
    w_capture    = 1'b0;
    w_take_hit   = 1'b0;
    w_take_res   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (x_valid && !x_kill) begin
          w_capture = 1'b1;
          if (w_hit) begin
            w_take_hit  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (x_kill) begin
          w_state_nxt = S_IDLE;
        end else begin
          op_vld = 1'b1;
          if (op_rdy) w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A kill landing on the result cycle has nothing left to drain.
        if (result_vld) begin
          if (x_kill) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_take_res  = 1'b1;
            w_state_nxt = S_DONE;
          end
        end else if (x_kill) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (result_vld) w_state_nxt = S_IDLE;
      end
      S_DONE: begin
        x_result_vld = !x_kill;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the cache data is reset along with its valid bit; it is one entry, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3 <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_c_vld  <= 1'b0;
      r_c_op   <= '0;
      r_c_a    <= '0;
      r_c_b    <= '0;
      r_c_hi   <= '0;
      r_c_lo   <= '0;
    end else begin
      if (w_capture) begin
        r_funct3 <= x_funct3;
        r_op     <= seq_op(x_funct3);
        r_a      <= x_rs1;
        r_b      <= x_rs2;
      end
      if (w_take_hit) r_result <= pick_half(x_funct3, r_c_hi, r_c_lo);
      if (w_take_res) begin
        r_result <= pick_half(r_funct3, result_h, result_l);
        r_c_vld  <= 1'b1;
        r_c_op   <= r_op;
        r_c_a    <= r_a;
        r_c_b    <= r_b;
        r_c_hi   <= result_h;
        r_c_lo   <= result_l;
      end
    end
  end

  assign x_stall  = x_valid && (r_state != S_DONE) && !x_kill;
  assign x_result = r_result;
  assign op       = r_op;
  assign op_a     = r_a;
  assign op_b     = r_b;
  assign op_force = 1'b0;

endmodule

// File: tb/tb_hazard5_muldiv_ctrl.sv
// Bench for hazard5_muldiv_ctrl: cached (index 0) and uncached (index 1) instances,
// each paired with a behavioural sequencer, checked against an arithmetic reference.
module tb_hazard5_muldiv_ctrl;

  logic        clk;
  logic        rst_n;

  logic        x_valid      [2];
  logic [2:0]  x_funct3     [2];
  logic [31:0] x_rs1        [2];
  logic [31:0] x_rs2        [2];
  logic        x_kill       [2];
  logic        x_stall      [2];
  logic [31:0] x_result     [2];
  logic        x_result_vld [2];
  logic [2:0]  op           [2];
  logic        op_vld       [2];
  logic        op_rdy       [2];
  logic        op_force     [2];
  logic [31:0] op_a         [2];
  logic [31:0] op_b         [2];
  logic [31:0] result_h     [2];
  logic [31:0] result_l     [2];
  logic        result_vld   [2];

  logic        seq_busy [2];
  int          seq_cnt  [2];
  logic [2:0]  seq_op   [2];
  logic [31:0] seq_a    [2];
  logic [31:0] seq_b    [2];
  int          hs_cnt   [2];
  logic [2:0]  last_op  [2];

  int          errors;
  int          checks;

  hazard5_muldiv_ctrl #(.XLEN(32), .CACHE_EN(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid[0]), .x_funct3(x_funct3[0]), .x_rs1(x_rs1[0]), .x_rs2(x_rs2[0]),
    .x_kill(x_kill[0]), .x_stall(x_stall[0]), .x_result(x_result[0]),
    .x_result_vld(x_result_vld[0]), .op(op[0]), .op_vld(op_vld[0]), .op_rdy(op_rdy[0]),
    .op_force(op_force[0]), .op_a(op_a[0]), .op_b(op_b[0]),
    .result_h(result_h[0]), .result_l(result_l[0]), .result_vld(result_vld[0])
  );

  hazard5_muldiv_ctrl #(.XLEN(32), .CACHE_EN(0)) u_dut_n (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid[1]), .x_funct3(x_funct3[1]), .x_rs1(x_rs1[1]), .x_rs2(x_rs2[1]),
    .x_kill(x_kill[1]), .x_stall(x_stall[1]), .x_result(x_result[1]),
    .x_result_vld(x_result_vld[1]), .op(op[1]), .op_vld(op_vld[1]), .op_rdy(op_rdy[1]),
    .op_force(op_force[1]), .op_a(op_a[1]), .op_b(op_b[1]),
    .result_h(result_h[1]), .result_l(result_l[1]), .result_vld(result_vld[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RISC-V M-extension result for one instruction, straight from the ISA rules.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ps, psu, pu;
    int          sa, sb, sq, sr;
    logic        ovf;
    ps  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    psu = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
    pu  = {32'b0, a} * {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    sa  = $signed(a);
    sb  = $signed(b);
    sq  = 0;
    sr  = 0;
    if (b != 32'd0 && !ovf) begin
      sq = sa / sb;
      sr = sa % sb;
    end
    case (f3)
      3'd0: return ps[31:0];
      3'd1: return ps[63:32];
      3'd2: return psu[63:32];
      3'd3: return pu[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf)        return a;
        return sq;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf)        return 32'd0;
        return sr;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Sequencer output pair {hi, lo} for a sequencer op code.
  function automatic logic [63:0] seq_result(input logic [2:0] sop, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [2:0] hf, lf;
    case (sop)
      3'd0, 3'd1: hf = 3'd1;
      3'd2:       hf = 3'd2;
      3'd3:       hf = 3'd3;
      3'd4:       hf = 3'd6;
      default:    hf = 3'd7;
    endcase
    lf = sop[2] ? sop : 3'd0;
    return {ref_result(hf, a, b), ref_result(lf, a, b)};
  endfunction

  // Which sequencer run an instruction needs, and which cached run can serve it.
  function automatic logic [2:0] issued_op(input logic [2:0] f3);
    case (f3)
      3'd6:    return 3'd4;
      3'd7:    return 3'd5;
      default: return f3;
    endcase
  endfunction

  function automatic bit compatible(input logic [2:0] f3, input logic [2:0] cop);
    case (f3)
      3'd0:       return cop inside {3'd0, 3'd1, 3'd2, 3'd3};
      3'd4, 3'd6: return cop == 3'd4;
      3'd5, 3'd7: return cop == 3'd5;
      default:    return cop == f3;
    endcase
  endfunction

  // Behavioural sequencer: random accept delay, random 1..5 cycle compute latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        op_rdy[g]     <= 1'b0;
        result_vld[g] <= 1'b0;
        result_h[g]   <= '0;
        result_l[g]   <= '0;
        seq_busy[g]   <= 1'b0;
        seq_cnt[g]    <= 0;
        seq_op[g]     <= '0;
        seq_a[g]      <= '0;
        seq_b[g]      <= '0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        result_vld[g] <= 1'b0;
        if (!seq_busy[g]) begin
          if (op_vld[g] && op_rdy[g]) begin
            seq_busy[g] <= 1'b1;
            seq_cnt[g]  <= int'($urandom_range(0, 4));
            seq_op[g]   <= op[g];
            seq_a[g]    <= op_a[g];
            seq_b[g]    <= op_b[g];
            last_op[g]  <= op[g];
            hs_cnt[g]   <= hs_cnt[g] + 1;
            op_rdy[g]   <= 1'b0;
          end else begin
            op_rdy[g] <= ($urandom_range(0, 2) != 0);
          end
        end else if (seq_cnt[g] == 0) begin
          result_vld[g] <= 1'b1;
          {result_h[g], result_l[g]} <= seq_result(seq_op[g], seq_a[g], seq_b[g]);
          seq_busy[g] <= 1'b0;
        end else begin
          seq_cnt[g] <= seq_cnt[g] - 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_x_result"}, x_result[d], 32'd0);
    check({tag, "_x_result_vld"}, 32'(x_result_vld[d]), 32'd0);
    check({tag, "_x_stall"}, 32'(x_stall[d]), 32'd0);
    check({tag, "_op_vld"}, 32'(op_vld[d]), 32'd0);
    check({tag, "_op"}, 32'(op[d]), 32'd0);
    check({tag, "_op_a"}, op_a[d], 32'd0);
    check({tag, "_op_b"}, op_b[d], 32'd0);
    check({tag, "_op_force"}, 32'(op_force[d]), 32'd0);
  endtask

  // Presents one instruction (called just after a rising edge) and holds it until
  // the result pulse, then advances past DONE and drops x_valid.
  task automatic do_op(input int d, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int cyc,
                       output bit got, output bit lat_ok);
    bit rv_prev;
    x_valid[d]  = 1'b1;
    x_funct3[d] = f3;
    x_rs1[d]    = a;
    x_rs2[d]    = b;
    got    = 1'b0;
    lat_ok = 1'b0;
    cyc    = 0;
    res    = '0;
    while (!got && cyc < 40) begin
      rv_prev = result_vld[d];
      @(posedge clk);
      #1;
      cyc++;
      if (x_result_vld[d]) begin
        got    = 1'b1;
        res    = x_result[d];
        lat_ok = rv_prev;
      end
    end
    @(posedge clk);
    #1;
    x_valid[d] = 1'b0;
  endtask

  task automatic run_check(input int d, input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input bit exp_hit);
    int          h0;
    logic [31:0] res;
    int          cyc;
    bit          got, lat_ok;
    h0 = hs_cnt[d];
    do_op(d, f3, a, b, res, cyc, got, lat_ok);
    check({tag, "_vld"}, 32'(got), 32'd1);
    check({tag, "_res"}, res, exp);
    check({tag, "_handshakes"}, 32'(hs_cnt[d] - h0), exp_hit ? 32'd0 : 32'd1);
    if (exp_hit) check({tag, "_hit_latency"}, 32'(cyc), 32'd1);
    else         check({tag, "_miss_latency"}, 32'(lat_ok), 32'd1);
  endtask

  // Presents an instruction and returns one cycle after its handshake (DUT in WAIT).
  task automatic start_to_wait(input int d, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b, output bit ok);
    x_valid[d]  = 1'b1;
    x_funct3[d] = f3;
    x_rs1[d]    = a;
    x_rs2[d]    = b;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = op_vld[d] && op_rdy[d];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] ra, rb, ca, cb;
  logic [2:0]  rf3, cop;
  bit          cv, hit, ok;
  int          pulses;

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    for (int d = 0; d < 2; d++) begin
      x_valid[d]  = 1'b0;
      x_kill[d]   = 1'b0;
      x_funct3[d] = '0;
      x_rs1[d]    = '0;
      x_rs2[d]    = '0;
      hs_cnt[d]   = 0;
      last_op[d]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0, "rst_c");
    check_reset_outputs(1, "rst_n");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fused MULHU + MUL
    run_check(0, "t1_mulhu", 3'd3, 32'h8000_0000, 32'd3, 32'h0000_0001, 1'b0);
    run_check(0, "t1_mul",   3'd0, 32'h8000_0000, 32'd3, 32'h8000_0000, 1'b1);

    // DIV + REM fused, REMU must re-run as DIVU
    run_check(0, "t2_div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_check(0, "t2_rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    run_check(0, "t2_remu", 3'd7, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 1'b0);
    check("t2_remu_issued_op", 32'(last_op[0]), 32'd5);

    // MULH and MULHU never share a run
    run_check(0, "t3_mulh",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_check(0, "t3_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);

    // Kill in WAIT: no result, no cache fill
    start_to_wait(0, 3'd5, 32'd100, 32'd7, ok);
    check("t4_reach_wait", 32'(ok), 32'd1);
    x_kill[0] = 1'b1;
    #1;
    check("t4_stall_on_kill", 32'(x_stall[0]), 32'd0);
    pulses = 0;
    @(posedge clk);
    #1;
    x_kill[0]  = 1'b0;
    x_valid[0] = 1'b0;
    repeat (20) begin
      if (x_result_vld[0]) pulses++;
      @(posedge clk);
      #1;
    end
    check("t4_killed_no_result", 32'(pulses), 32'd0);
    run_check(0, "t4_remu", 3'd7, 32'd100, 32'd7, 32'h0000_0002, 1'b0);

    // Divide by zero is cacheable; reset mid-WAIT clears everything
    run_check(0, "t5_divu0", 3'd5, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_check(0, "t5_remu0", 3'd7, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1);
    run_check(0, "t5_mul_pre", 3'd0, 32'd3, 32'd5, 32'h0000_000F, 1'b0);
    start_to_wait(0, 3'd5, 32'd9, 32'd3, ok);
    check("t5_reach_wait", 32'(ok), 32'd1);
    x_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0, "t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_check(0, "t5_mul_post", 3'd0, 32'd3, 32'd5, 32'h0000_000F, 1'b0);

    // Random pairs on the cached instance against a cache-hit prediction
    pulse_reset();
    cv = 1'b0;
    cop = '0;
    ca = '0;
    cb = '0;
    for (int i = 0; i < 200 && errors < 50; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      for (int k = 0; k < 2; k++) begin
        rf3 = 3'($urandom_range(0, 7));
        hit = cv && (ca == ra) && (cb == rb) && compatible(rf3, cop);
        run_check(0, $sformatf("rc%0d_%0d_f%0d", i, k, rf3), rf3, ra, rb,
                  ref_result(rf3, ra, rb), hit);
        if (!hit) begin
          cv  = 1'b1;
          cop = issued_op(rf3);
          ca  = ra;
          cb  = rb;
        end
      end
    end

    // Uncached instance: 1000 paired ops, every one must hit the sequencer
    for (int i = 0; i < 500 && errors < 50; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      for (int k = 0; k < 2; k++) begin
        rf3 = 3'($urandom_range(0, 7));
        run_check(1, $sformatf("rn%0d_%0d_f%0d", i, k, rf3), rf3, ra, rb,
                  ref_result(rf3, ra, rb), 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard5_muldiv_ctrl.md
Name: hazard5_muldiv_ctrl

Overview:
Pipeline-side controller that sits between Hazard5 execute-stage M-extension decode and hazard5_muldiv_seq.
- Accepts one RISC-V M instruction at a time (funct3 plus rs1/rs2 values).
- Drives the sequencer's op_vld/op_rdy handshake and stalls the pipeline until the result is ready.
- Selects result_h or result_l for writeback.
- Keeps a one-entry result cache, so fused pairs (MULH*+MUL, DIV+REM on identical operands) complete without re-running the sequencer.

Parameters:
XLEN, 32, datapath width; must match the sequencer.
CACHE_EN, 1, 1 enables the one-entry result cache; 0 makes every instruction a miss.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
x_valid  in  1  M instruction present in execute; x_* held stable while x_stall=1
x_funct3  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
x_rs1  in  XLEN  operand a
x_rs2  in  XLEN  operand b
x_kill  in  1  flush current instruction
x_stall  out  1  hold execute stage
x_result  out  XLEN  writeback value
x_result_vld  out  1  x_result valid, one-cycle pulse
op  out  3  sequencer op (encoding = funct3; REM/REMU issued as DIV/DIVU, i.e. funct3 & 3'b101)
op_vld  out  1  request to sequencer
op_rdy  in  1  sequencer accepts
op_force  out  1  tied 0
op_a  out  XLEN  registered x_rs1
op_b  out  XLEN  registered x_rs2
result_h  in  XLEN  sequencer high result / remainder
result_l  in  XLEN  sequencer low result / quotient
result_vld  in  1  sequencer result valid

Behaviour:
- States: IDLE, ISSUE, WAIT, DRAIN, DONE. Reset to IDLE.
- Reset values: all outputs 0; cache invalid; result register 0. Async reset mid-operation returns to IDLE; the sequencer shares rst_n.
- IDLE, on x_valid && !x_kill:
  - Capture funct3, rs1, rs2.
  - Cache hit → DONE next cycle; no op_vld is asserted.
  - Miss → ISSUE.
- ISSUE:
  - op_vld=1 with op, op_a, op_b from the capture registers.
  - op_rdy → WAIT.
  - x_kill → IDLE, op_vld dropped the same cycle.
- WAIT:
  - result_vld → latch result_h/result_l into the result register, write the cache, go to DONE.
  - x_kill → DRAIN.
- DRAIN: wait for result_vld, discard it, do not write the cache, go to IDLE.
- DONE: x_result_vld=1, x_stall=0 → IDLE. x_kill in DONE suppresses x_result_vld.
- x_stall = x_valid && state!=DONE && !x_kill.
- Miss latency: x_result_vld asserts 1 cycle after result_vld.
- Hit latency: x_result_vld asserts 1 cycle after x_valid sampled.
- Result select:
  - MUL, DIV, DIVU → result_l.
  - MULH, MULHSU, MULHU, REM, REMU → result_h.
- Cache entry contents: valid, seq op, a, b, hi, lo.
- Hit condition: valid && a==x_rs1 && b==x_rs2 && compatible:
  - MUL hits on any cached mul-class op (low half is signedness-independent).
  - MULH/MULHSU/MULHU hit only on the identical seq op.
  - DIV/REM hit on cached DIV; DIVU/REMU hit on cached DIVU.
  - mul-class never matches div-class.
- Divide-by-zero and signed overflow results come from the sequencer unmodified and are cacheable.
- Back-to-back instructions: a new x_valid is sampled in the cycle after DONE (one idle bubble).
- CACHE_EN=0: hit forced 0, cache registers may be removed.

Test Plan:
1. MULHU a=0x80000000 b=0x00000003 then MUL same operands → 0x00000001 then 0x80000000; exactly one op_vld handshake; MUL x_result_vld 1 cycle after x_valid.
2. DIV a=0xFFFFFFF9 b=0x00000002 then REM same operands → 0xFFFFFFFD then 0xFFFFFFFF; REM issues no op_vld. Then REMU same operands → miss, issued as DIVU, result 0x00000001.
3. MULH then MULHU, a=0xFFFFFFFF b=0xFFFFFFFF → 0x00000000 then 0xFFFFFFFE; second is a miss (two handshakes).
4. x_kill asserted in WAIT on DIVU 100/7, then REMU 100/7 → killed op gives no x_result_vld and no cache write; REMU re-issues and returns 0x00000002.
5. DIVU a=0x12345678 b=0 then REMU same → 0xFFFFFFFF then 0x12345678 (cache hit). Also rst_n pulsed during WAIT → all outputs 0, next MUL 3*5 returns 0x0000000F as a miss.
6. CACHE_EN=0 with 1000 random paired ops vs a golden model → every instruction performs a handshake and all results match.
